// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register select, data word and the write-sequencer queue entry.
// Also holds the default sequencer depth and a small enqueue-count helper.
package cpu_types_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned WORD_W = 32;

    typedef logic [REG_W-1:0]  regbits_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        regbits_t sel;
        word_t    dat;
    } wseq_entry_t;

    localparam int unsigned WSEQ_DEPTH = 4;

    function automatic logic [1:0] wseq_enq_count(input logic first, input logic second);
        return {1'b0, first} + {1'b0, second};
    endfunction

endpackage

// File: rtl/rf_wseq_fifo.sv
// Circular buffer for the write sequencer: two ordered writes and one read per cycle.
// Exports the occupancy and the entries in age order (index 0 = oldest).
module rf_wseq_fifo
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = WSEQ_DEPTH,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     wr0_en,
    input  wseq_entry_t              wr0_entry,
    input  logic                     wr1_en,
    input  wseq_entry_t              wr1_entry,
    input  logic                     rd_en,
    output wseq_entry_t              head,
    output logic [CW-1:0]            count,
    output wseq_entry_t [DEPTH-1:0]  entries
);

    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    wseq_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [1:0]              enq;
    logic [PW-1:0]           wr_ptr_nxt;

    always_comb begin
        enq        = wseq_enq_count(wr0_en, wr1_en);
        wr_ptr_nxt = wr_ptr_q + PW'(1);
        wr_ptr_d   = wr_ptr_q + PW'(enq);
        rd_ptr_d   = rd_ptr_q + PW'(rd_en);
        // Single expression so a simultaneous push and pop never double-counts.
        count_d    = count_q + CW'(enq) - CW'(rd_en);
        mem_d      = mem_q;
        if (wr0_en) begin
            mem_d[wr_ptr_q] = wr0_entry;
        end
        if (wr1_en) begin
            mem_d[wr_ptr_nxt] = wr1_entry;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    always_comb begin
        head  = mem_q[rd_ptr_q];
        count = count_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            entries[i] = mem_q[rd_ptr_q + PW'(i)];
        end
    end

    assert property (@(posedge CLK) disable iff (!nRST) (wr1_en |-> wr0_en));
    assert property (@(posedge CLK) disable iff (!nRST) (rd_en |-> (count_q != '0)));
    assert property (@(posedge CLK) disable iff (!nRST)
                     (int'(count_q) + int'(enq) - int'(rd_en) <= int'(DEPTH)));

endmodule

// File: rtl/rf_write_sequencer.sv
// Register-file write port sequencer: merges producers A and B into one ordered write stream.
// Optional store-to-read forwarding search is enabled by defining RF_WSEQ_FWD_EN.
module rf_write_sequencer
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = WSEQ_DEPTH
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         a_valid,
    output logic                         a_ready,
    input  logic [4:0]                   a_sel,
    input  logic [31:0]                  a_dat,
    input  logic                         b_valid,
    output logic                         b_ready,
    input  logic [4:0]                   b_sel,
    input  logic [31:0]                  b_dat,
    input  logic                         whold,
    output logic                         WEN,
    output logic [4:0]                   wsel,
    output logic [31:0]                  wdat,
    output logic [$clog2(DEPTH+1)-1:0]   pending
`ifdef RF_WSEQ_FWD_EN
    ,
    input  logic [4:0]                   fwd_sel,
    output logic                         fwd_hit,
    output logic [31:0]                  fwd_dat
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0]           count;
    logic [CW-1:0]           free;
    wseq_entry_t             head;
    wseq_entry_t [DEPTH-1:0] entries;
    logic                    a_nz, b_nz;
    logic                    a_enq, b_enq;
    logic                    wr0_en, wr1_en;
    wseq_entry_t             wr0_entry, wr1_entry;
    logic                    pop;

    logic                    wen_q;
    logic [4:0]              wsel_q;
    logic [31:0]             wdat_q;

    always_comb begin
        a_nz = a_sel != '0;
        b_nz = b_sel != '0;
        free = CW'(DEPTH) - count;
        // A has priority on the last free slot; B never looks at whether A is ready.
        a_ready = !a_nz || (free >= CW'(1));
        b_ready = !b_nz || (free >= CW'(2)) || ((free == CW'(1)) && !(a_valid && a_nz));
        a_enq   = a_valid && a_ready && a_nz;
        b_enq   = b_valid && b_ready && b_nz;
    end

    always_comb begin
        wr0_en    = a_enq || b_enq;
        wr1_en    = a_enq && b_enq;
        wr0_entry = a_enq ? wseq_entry_t'{sel: a_sel, dat: a_dat}
                          : wseq_entry_t'{sel: b_sel, dat: b_dat};
        wr1_entry = wseq_entry_t'{sel: b_sel, dat: b_dat};
        pop       = (count != '0) && !whold;
    end

    rf_wseq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .nRST      (nRST),
        .wr0_en    (wr0_en),
        .wr0_entry (wr0_entry),
        .wr1_en    (wr1_en),
        .wr1_entry (wr1_entry),
        .rd_en     (pop),
        .head      (head),
        .count     (count),
        .entries   (entries)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wen_q  <= 1'b0;
            wsel_q <= '0;
            wdat_q <= '0;
        end else begin
            wen_q <= pop;
            if (pop) begin
                wsel_q <= head.sel;
                wdat_q <= head.dat;
            end
        end
    end

    assign WEN     = wen_q;
    assign wsel    = wsel_q;
    assign wdat    = wdat_q;
    assign pending = count;

`ifdef RF_WSEQ_FWD_EN
    // Output register is older than every queued entry, so it is checked first
    // and any later queue match overrides it.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_dat = '0;
        if (fwd_sel != '0) begin
            if (wen_q && (wsel_q == fwd_sel)) begin
                fwd_hit = 1'b1;
                fwd_dat = wdat_q;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                if ((CW'(i) < count) && (entries[i].sel == fwd_sel)) begin
                    fwd_hit = 1'b1;
                    fwd_dat = entries[i].dat;
                end
            end
        end
    end
`else
    logic unused_entries;
    assign unused_entries = ^entries;
`endif

endmodule
